// File: rtl/pcm_linear_interpolator.sv
// PCM linear interpolator: upsamples 16-bit PCM by OSR = 2**LOG2_OSR with a linear ramp per segment.
// Optional PCM_INTERP_UNDERRUN_CNT_EN adds a saturating underrun counter port.
module pcm_linear_interpolator #(
  parameter int LOG2_OSR = 7,
  parameter int DW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out,
  output logic          sample_tick,
`ifdef PCM_INTERP_UNDERRUN_CNT_EN
  output logic [15:0]   underrun_cnt,
`endif
  output logic          underrun
);
  localparam int AW = DW + LOG2_OSR + 1;
  localparam int SW = DW + 1;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;

  logic [DW-1:0]       hold_q, hold_d;
  logic                hold_valid_q, hold_valid_d;
  logic [DW-1:0]       cur_q, cur_d;
  logic [SW-1:0]       step_q, step_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic [LOG2_OSR-1:0] phase_q, phase_d;
  logic                tick_q, tick_d, und_q, und_d;
  logic                wrap, accept, load;

  assign wrap   = (state_q == RUN) && (&phase_q);
  assign accept = in_valid && !hold_valid_q;
  assign load   = hold_valid_q && ((state_q == IDLE) || wrap);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && hold_valid_q) state_d = RUN;
  end

  always_comb begin
    hold_d       = accept ? in_data : hold_q;
    hold_valid_d = accept | (hold_valid_q & ~load);
    cur_d        = cur_q;
    step_d       = step_q;
    acc_d        = acc_q;
    phase_d      = phase_q;
    tick_d       = 1'b0;
    und_d        = 1'b0;
    if (state_q == IDLE) begin
      if (load) begin
        cur_d   = hold_q;
        step_d  = {hold_q[DW-1], hold_q};
        phase_d = '0;
      end
    end else begin
      acc_d   = acc_q + {{(AW-SW){step_q[SW-1]}}, step_q};
      phase_d = phase_q + 1'b1;
      if (wrap) begin
        // Exact reload removes any accumulated drift and equals acc + step anyway.
        acc_d  = {{(AW-DW-LOG2_OSR){cur_q[DW-1]}}, cur_q, {LOG2_OSR{1'b0}}};
        tick_d = 1'b1;
        if (hold_valid_q) begin
          step_d = {hold_q[DW-1], hold_q} - {cur_q[DW-1], cur_q};
          cur_d  = hold_q;
        end else begin
          step_d = '0;
          und_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      cur_q        <= '0;
      step_q       <= '0;
      acc_q        <= '0;
      phase_q      <= '0;
      tick_q       <= 1'b0;
      und_q        <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      cur_q        <= cur_d;
      step_q       <= step_d;
      acc_q        <= acc_d;
      phase_q      <= phase_d;
      tick_q       <= tick_d;
      und_q        <= und_d;
    end
  end

`ifdef PCM_INTERP_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;
  always_comb begin
    ucnt_d = ucnt_q;
    if (und_d && ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
  end
  always_ff @(posedge clk) begin
    if (reset) ucnt_q <= '0;
    else       ucnt_q <= ucnt_d;
  end
  assign underrun_cnt = ucnt_q;
`endif

  // Segment values stay between prev and cur targets, so the slice never overflows.
  assign out         = acc_q[LOG2_OSR +: DW];
  assign in_ready    = !hold_valid_q;
  assign sample_tick = tick_q;
  assign underrun    = und_q;
endmodule

// File: tb/tb_pcm_linear_interpolator.sv
// Bench for pcm_linear_interpolator: randomized and directed stimulus against a segment-level model.
module tb_pcm_linear_interpolator;
  localparam int LOG2_OSR = 7;
  localparam int OSR      = 1 << LOG2_OSR;

  logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, sample_tick, underrun;
  logic [15:0] out;
`ifdef PCM_INTERP_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif
  int errors = 0, checks = 0;

  pcm_linear_interpolator #(.LOG2_OSR(LOG2_OSR), .DW(16)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out(out), .sample_tick(sample_tick),
`ifdef PCM_INTERP_UNDERRUN_CNT_EN
    .underrun_cnt(underrun_cnt),
`endif
    .underrun(underrun));

  always #5 clk = ~clk;

  // Segment model: out = prev + floor(k * (tgt - prev) / OSR), k = cycles into segment.
  bit m_run, m_tick, m_und;
  int m_hold[$];
  int m_k, m_prev, m_tgt, m_cnt;

  function automatic int fdiv(int a, int b);
    int q = a / b;
    if ((a % b) != 0 && a < 0) q--;
    return q;
  endfunction

  function automatic int m_out();
    return m_run ? m_prev + fdiv(m_k * (m_tgt - m_prev), OSR) : 0;
  endfunction

  task automatic clk_step();
    bit acc;
    @(posedge clk);
    if (reset) begin
      m_run = 0; m_hold.delete(); m_k = 0; m_prev = 0; m_tgt = 0; m_tick = 0; m_und = 0; m_cnt = 0;
    end else begin
      acc = in_valid && (m_hold.size() == 0);
      m_tick = 0; m_und = 0;
      if (!m_run) begin
        if (m_hold.size() > 0) begin m_run = 1; m_prev = 0; m_tgt = m_hold.pop_front(); m_k = 0; end
      end else if (m_k == OSR - 1) begin
        m_k = 0; m_tick = 1; m_prev = m_tgt;
        if (m_hold.size() > 0) m_tgt = m_hold.pop_front();
        else begin m_und = 1; if (m_cnt < 65535) m_cnt++; end
      end else m_k++;
      if (acc) m_hold.push_back(int'($signed(in_data)));
    end
    #1;
  endtask

  task automatic push(input logic [15:0] v);
    int n = 0;
    while (!in_ready && n < 400) begin clk_step(); n++; end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL push_timeout in_ready=%b want=1", in_ready); end
    in_valid = 1'b1; in_data = v;
    clk_step();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0;
    clk_step(); clk_step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 4;
    if (out !== 16'h0)       begin errors++; $display("FAIL reset_out got=%h want=0000", out); end
    if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_ready got=%b want=1", in_ready); end
    if (sample_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b want=0", sample_tick); end
    if (underrun !== 1'b0)   begin errors++; $display("FAIL reset_underrun got=%b want=0", underrun); end
`ifdef PCM_INTERP_UNDERRUN_CNT_EN
    checks++;
    if (underrun_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got=%0d want=0", underrun_cnt); end
`endif
    clk_step();
    checks++;
    if (out !== 16'h0) begin errors++; $display("FAIL idle_out got=%h want=0000", out); end
  endtask

  task automatic test_ramp();
    push(16'h4000);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL ramp_ready_low got=%b want=0", in_ready); end
    clk_step();
    checks++;
    if (in_ready !== 1'b1 || out !== 16'h0) begin
      errors++; $display("FAIL ramp_entry ready=%b out=%h want ready=1 out=0000", in_ready, out);
    end
    for (int i = 1; i <= OSR; i++) begin
      in_valid = (i == 64); in_data = 16'hC000;
      clk_step();
      checks++;
      if ($signed(out) !== i * 128 || $signed(out) !== m_out()) begin
        errors++; $display("FAIL ramp_out i=%0d got=%0d want=%0d", i, $signed(out), i * 128);
      end
      checks++;
      if (sample_tick !== (i == OSR)) begin
        errors++; $display("FAIL ramp_tick i=%0d got=%b want=%b", i, sample_tick, i == OSR);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (out !== 16'h4000 || underrun !== 1'b0) begin
      errors++; $display("FAIL ramp_end out=%h und=%b want 4000 und=0", out, underrun);
    end
  endtask

  task automatic test_negative_step();
    for (int i = 1; i <= OSR; i++) begin
      clk_step();
      checks++;
      if ($signed(out) !== 16384 - 256 * i || $signed(out) < -16384) begin
        errors++; $display("FAIL neg_out i=%0d got=%0d want=%0d", i, $signed(out), 16384 - 256 * i);
      end
    end
    checks++;
    if (out !== 16'hC000 || sample_tick !== 1'b1 || underrun !== 1'b1) begin
      errors++; $display("FAIL neg_end out=%h tick=%b und=%b want C000 1 1", out, sample_tick, underrun);
    end
  endtask

  task automatic test_full_scale();
    int prev;
    do_reset();
    push(16'h7FFF);
    clk_step();
    for (int i = 1; i <= OSR; i++) begin
      in_valid = (i == 10); in_data = 16'h8000;
      clk_step();
      checks++;
      if ($signed(out) !== m_out()) begin
        errors++; $display("FAIL fs_up i=%0d got=%0d want=%0d", i, $signed(out), m_out());
      end
    end
    in_valid = 1'b0;
    checks++;
    if (out !== 16'h7FFF) begin errors++; $display("FAIL fs_top got=%h want=7fff", out); end
    prev = 32767;
    for (int i = 1; i <= OSR; i++) begin
      clk_step();
      checks++;
      if ($signed(out) > prev || $signed(out) !== m_out()) begin
        errors++; $display("FAIL fs_down i=%0d got=%0d want=%0d prev=%0d", i, $signed(out), m_out(), prev);
      end
      prev = $signed(out);
    end
    checks++;
    if (out !== 16'h8000) begin errors++; $display("FAIL fs_bottom got=%h want=8000", out); end
  endtask

  task automatic test_underrun();
    int unds = 0;
    do_reset();
    push(16'h1000);
    clk_step();
    for (int i = 1; i <= 3 * OSR; i++) begin
      clk_step();
      if (underrun === 1'b1) unds++;
      checks++;
      if (underrun !== m_und || $signed(out) !== m_out()) begin
        errors++; $display("FAIL und_cycle i=%0d und=%b out=%0d want und=%b out=%0d", i, underrun, $signed(out), m_und, m_out());
      end
      if (i >= OSR) begin
        checks++;
        if (out !== 16'h1000) begin errors++; $display("FAIL und_hold i=%0d got=%h want=1000", i, out); end
      end
    end
    checks++;
    if (unds !== 3) begin errors++; $display("FAIL und_pulses got=%0d want=3", unds); end
`ifdef PCM_INTERP_UNDERRUN_CNT_EN
    checks++;
    if (underrun_cnt !== 16'd3) begin errors++; $display("FAIL und_cnt got=%0d want=3", underrun_cnt); end
`endif
  endtask

  task automatic test_back_to_back();
    int ticks = 0, accs = 0;
    bit rdy;
    do_reset();
    in_valid = 1'b1; in_data = 16'd1;
    for (int i = 0; i < 520; i++) begin
      rdy = in_ready;
      clk_step();
      if (rdy) begin accs++; in_data = in_data + 16'd1; end
      checks++;
      if (in_ready !== (m_hold.size() == 0) || $signed(out) !== m_out()) begin
        errors++; $display("FAIL b2b_cycle i=%0d ready=%b out=%0d want out=%0d", i, in_ready, $signed(out), m_out());
      end
      if (sample_tick === 1'b1) begin
        ticks++;
        checks++;
        if ($signed(out) !== ticks || underrun !== 1'b0) begin
          errors++; $display("FAIL b2b_target tick=%0d got=%0d und=%b want=%0d und=0", ticks, $signed(out), underrun, ticks);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (ticks !== 4 || accs !== 6) begin
      errors++; $display("FAIL b2b_counts ticks=%0d accepts=%0d want 4 6", ticks, accs);
    end
  endtask

  task automatic test_reset_mid_ramp();
    do_reset();
    push(16'h4000);
    clk_step();
    for (int i = 1; i <= 60; i++) begin
      in_valid = (i == 30); in_data = 16'h7000;
      clk_step();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    clk_step();
    checks++;
    if (out !== 16'h0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midrst out=%h ready=%b want 0000 1", out, in_ready);
    end
    reset = 1'b0;
    push(16'h2000);
    clk_step();
    for (int i = 1; i <= OSR; i++) begin
      clk_step();
      checks++;
      if ($signed(out) !== i * 64) begin
        errors++; $display("FAIL midrst_ramp i=%0d got=%0d want=%0d", i, $signed(out), i * 64);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 99) < 2);
      in_data  = 16'($urandom);
      clk_step();
      checks++;
      if ($signed(out) !== m_out() || in_ready !== (m_hold.size() == 0) ||
          sample_tick !== m_tick || underrun !== m_und) begin
        errors++;
        $display("FAIL rand i=%0d out=%0d rdy=%b tick=%b und=%b want out=%0d rdy=%b tick=%b und=%b",
                 i, $signed(out), in_ready, sample_tick, underrun, m_out(), m_hold.size() == 0, m_tick, m_und);
      end
`ifdef PCM_INTERP_UNDERRUN_CNT_EN
      checks++;
      if (underrun_cnt !== 16'(m_cnt)) begin
        errors++; $display("FAIL rand_cnt i=%0d got=%0d want=%0d", i, underrun_cnt, m_cnt);
      end
`endif
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_negative_step();
    test_full_scale();
    test_underrun();
    test_back_to_back();
    test_reset_mid_ramp();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pcm_linear_interpolator.md
Name: pcm_linear_interpolator

Overview:
- Upstream stage of the second-order sigma-delta modulator. Accepts 16-bit signed PCM samples at base rate fs through a valid/ready handshake.
- Produces one 16-bit signed sample on every clk, at OSR × fs, by linear interpolation between consecutive input samples.
- Output drives the modulator's 16-bit `in` port directly on the same clock.
- Owns the sample cadence: it requests exactly one sample per OSR clocks and flags underruns.

Parameters:
- LOG2_OSR, 7, log2 of the oversampling ratio. OSR = 2**LOG2_OSR; default 128 matches the modulator clock.
- DW, 16, PCM sample width (fixed at 16 for the modulator interface; parameterised for the bench only).

Ports:
- clk  input  1  oversampled clock (OSR × fs), shared with the modulator
- reset  input  1  synchronous, active-high reset
- in_data  input  16  signed PCM sample
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  block can accept a sample this cycle
- out  output  16  signed interpolated sample, registered, one per clk
- sample_tick  output  1  one-cycle pulse at each segment boundary (phase wrap)
- underrun  output  1  one-cycle pulse when a segment boundary finds no sample held
- underrun_cnt  output  16  saturating underrun count; present only with PCM_INTERP_UNDERRUN_CNT_EN

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Internal state:
  - hold / hold_valid: one-entry input holding register.
  - cur: 16-bit current segment target.
  - step: 17-bit signed, cur − previous target.
  - acc: signed, DW+LOG2_OSR+1 bits.
  - phase: LOG2_OSR-bit counter.
  - state: IDLE or RUN.
- Reset, while reset is high at a clk edge: state=IDLE, acc=0, cur=0, step=0, phase=0, hold_valid=0. Outputs: out=0, in_ready=1, sample_tick=0, underrun=0, underrun_cnt=0. Reset mid-ramp discards hold and the ramp; out=0 on the cycle after the reset edge.
- Handshake:
  - in_ready = !hold_valid, derived from a register only.
  - Transfer happens when in_valid && in_ready; on transfer, hold<=in_data and hold_valid<=1.
  - in_data is ignored when in_ready=0.
  - No bypass: a sample accepted in a wrap cycle is not consumed by that wrap.
- IDLE:
  - out holds 0; phase does not count.
  - When hold_valid=1: next edge gives cur<=hold, step<=hold−0, hold_valid<=0, phase<=0, state<=RUN.
  - Result: the output ramps from 0 to the first sample over OSR cycles.
- RUN, every cycle: acc<=acc+sign_ext(step) and phase<=phase+1 (wraps mod OSR).
- Wrap cycle (phase==OSR−1 in RUN):
  - acc<=cur<<<LOG2_OSR, an exact reload equal to acc+step.
  - sample_tick<=1.
  - If hold_valid: step<=hold−cur, cur<=hold, hold_valid<=0.
  - Else: step<=0, cur unchanged, underrun<=1. The output then holds the last value for one segment.
- out = acc >>> LOG2_OSR (arithmetic shift, floor), taken from the acc register, so out is registered.
  - Segment values are bounded by prev and cur; no overflow or saturation is needed.
  - Full-scale step −65535 fits in 17 bits.
- Latency: a sample accepted during segment k becomes the target at the wrap ending segment k. out equals it exactly OSR cycles after that wrap.
- RUN never returns to IDLE except by reset.
- sample_tick and underrun are one-cycle pulses, registered, and asserted on the cycle after the wrap cycle.

Optional Feature:
- Macro: PCM_INTERP_UNDERRUN_CNT_EN.
- Defined:
  - underrun_cnt port exists.
  - Increments by 1 on every underrun event and saturates at 0xFFFF.
  - Cleared only by reset.
- Undefined: port and counter are absent; the underrun pulse is unchanged.

Test Plan:
- Reset, then push 0x4000 → in_ready falls for 1 cycle. After RUN entry, out rises by 128 per clk and equals 0x4000 exactly 128 cycles later. sample_tick pulses every 128 cycles.
- At 0x4000, push 0xC000 (−16384) before the wrap → next segment out falls by 256 per clk and reaches 0xC000 at the end of the segment, no overshoot.
- Full scale: 0x7FFF then 0x8000 → out descends monotonically from 32767 to −32768 with no wrap-around glitch.
- Upstream stalls after 0x1000 → out holds 0x1000 and underrun pulses once per 128 cycles. With PCM_INTERP_UNDERRUN_CNT_EN, underrun_cnt = 3 after three empty wraps.
- Backpressure: hold in_valid=1 continuously with incrementing data → exactly one accept per 128 cycles. in_ready is low between accepts; no sample is lost or duplicated.
- Assert reset at phase 60 of a ramp → next cycle out=0 and in_ready=1. The next sample ramps from 0.
